// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// sizes and a ceiling-log2 helper usable in parameter expressions.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_t;

    // Ceiling log2, never below 1 so single-bit indices stay legal.
    function automatic int uart_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req starting at rr_ptr, wrapping
// modulo NUM_REQ, and reports the first set bit as one-hot and as an index.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = uart_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // First requester at or after rr_ptr wins; unused index codes never appear.
    always_comb begin
        int cand;
        logic [IDX_W-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                idx             = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART serializer among NUM_REQ byte
// sources. Launches a byte with a one-cycle start pulse, waits for the
// serializer to go busy (with timeout) and then idle, and supports per-source
// locking so multi-byte messages are not interleaved.
//
// Handshake: a requester holds req/req_data stable until it sees its ack
// pulse; ack coincides with tx_start. On the cycle after ack it either drops
// req or presents its next byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT,
    localparam int IDX_W       = uart_clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      active,
    output logic                      err,
    output state_t                    fsm_state
);

    localparam int CNT_W = uart_clog2(BUSY_TIMEOUT) + 1;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  pick_data;
    logic [DATA_W-1:0]  held_data;
    logic [IDX_W-1:0]   ptr_next;
    logic               frame_done;
    logic               relock;
    logic               take_new;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Byte muxes for the new winner and for the currently granted source.
    always_comb begin
        pick_data = '0;
        held_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
            if (grant_id == IDX_W'(i)) begin
                held_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A frame ends when busy is seen low in WAIT_IDLE; a locked source keeps
    // the transmitter, otherwise arbitration happens on that same edge so the
    // next launch has the same one-cycle latency either way.
    assign ptr_next   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign frame_done = (state == ST_WAIT_IDLE) && !tx_busy;
    assign relock     = frame_done && req_lock[grant_id] && req[grant_id];
    assign take_new   = pick_any && !relock && ((state == ST_IDLE) || frame_done);

    assign active    = (state != ST_IDLE);
    assign fsm_state = state;

    // Single-process FSM with registered launch pulses and busy timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            if (take_new) begin
                grant_id <= pick_idx;
                tx_data  <= pick_data;
                rr_ptr   <= ptr_next;
                tx_start <= 1'b1;
                ack      <= pick_grant;
            end else if (relock) begin
                tx_data  <= held_data;
                tx_start <= 1'b1;
                ack      <= NUM_REQ'(1) << grant_id;
            end
            case (state)
                ST_IDLE: begin
                    if (take_new) begin
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Counter reaches BUSY_TIMEOUT-1 on this edge.
                        if (cnt == CNT_W'(BUSY_TIMEOUT - 2)) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        state <= (relock || take_new) ? ST_LAUNCH : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Inputs change and outputs are sampled
// on the falling clock edge; the serializer's busy flag is driven by tasks.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [1:0]                grant_id;
    logic                      active;
    logic                      err;
    state_t                    fsm_state;

    int n_tests;
    int n_fail;
    int start_count;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_lock  (req_lock),
        .req_data  (req_data),
        .ack       (ack),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_start === 1'b1) start_count++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        tx_busy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a launch and checks ack, grant_id and tx_data.
    task automatic expect_launch(input int idx, input logic [7:0] data,
                                 input string name, output int waited);
        logic [NUM_REQ-1:0] exp_ack;
        exp_ack = NUM_REQ'(1) << idx;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (tx_start !== 1'b1 && waited < 40);
        n_tests++;
        if (tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start: tx_start=%b after %0d cycles, expected 1", name, tx_start, waited);
        end else begin
            n_tests++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL %s_ack: got %b expected %b", name, ack, exp_ack);
            end
            n_tests++;
            if (grant_id !== 2'(idx)) begin
                n_fail++;
                $display("FAIL %s_grant: got %0d expected %0d", name, grant_id, idx);
            end
            n_tests++;
            if (tx_data !== data) begin
                n_fail++;
                $display("FAIL %s_data: got %h expected %h", name, tx_data, data);
            end
        end
    endtask

    // Serializer model: called on the launch cycle, goes busy for busy_len cycles.
    task automatic serve(input int busy_len);
        tick();
        tx_busy = 1'b1;
        repeat (busy_len) tick();
        tx_busy = 1'b0;
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if (fsm_state !== ST_IDLE || active !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: state=%0d active=%b expected state=0 active=0", name, fsm_state, active);
        end
    endtask

    task automatic test_reset();
        req      = '1;
        req_lock = '0;
        req_data = 32'h44332211;
        do_reset();
        reset = 1'b1;
        n_tests++;
        if (tx_start !== 1'b0 || ack !== 4'b0 || grant_id !== 2'd0 || tx_data !== 8'h00 ||
            active !== 1'b0 || err !== 1'b0 || fsm_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_values: start=%b ack=%b gid=%0d data=%h active=%b err=%b state=%0d expected all 0",
                     tx_start, ack, grant_id, tx_data, active, err, fsm_state);
        end
        req   = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int w;
        set_byte(2, 8'h41);
        req = 4'b0100;
        expect_launch(2, 8'h41, "single", w);
        n_tests++;
        if (w != 1 || fsm_state !== ST_LAUNCH) begin
            n_fail++;
            $display("FAIL single_latency: waited %0d state=%0d expected 1 cycle in LAUNCH", w, fsm_state);
        end
        req = '0;
        serve(10);
        n_tests++;
        if (fsm_state !== ST_WAIT_IDLE || tx_data !== 8'h41) begin
            n_fail++;
            $display("FAIL single_hold: state=%0d data=%h expected 3 and 41", fsm_state, tx_data);
        end
        tick();
        check_idle("single");
        // rr_ptr is now 3: of requesters 1 and 3, 3 wins.
        set_byte(1, 8'hB1);
        set_byte(3, 8'hB3);
        req = 4'b1010;
        expect_launch(3, 8'hB3, "single_ptr", w);
        req[3] = 1'b0;
        serve(2);
        expect_launch(1, 8'hB1, "single_ptr_next", w);
        req[1] = 1'b0;
        serve(2);
        tick();
    endtask

    task automatic test_contention();
        int w;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_byte(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) begin
            expect_launch(k, 8'(8'h10 + k), "contention", w);
            n_tests++;
            if (w != 1) begin
                n_fail++;
                $display("FAIL contention_latency%0d: waited %0d expected 1", k, w);
            end
            req[k] = 1'b0;
            serve(3);
        end
        req = 4'b0011;
        expect_launch(0, 8'h10, "contention_wrap", w);
        req[0] = 1'b0;
        serve(2);
        expect_launch(1, 8'h11, "contention_wrap1", w);
        req[1] = 1'b0;
        serve(2);
        tick();
        check_idle("contention");
    endtask

    task automatic test_lock_burst();
        int w;
        do_reset();
        set_byte(1, 8'h48);
        set_byte(3, 8'h33);
        req      = 4'b1010;
        req_lock = 4'b0010;
        expect_launch(1, 8'h48, "lock0", w);
        set_byte(1, 8'h49);
        serve(4);
        expect_launch(1, 8'h49, "lock1", w);
        n_tests++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL lock_latency: waited %0d expected 1", w);
        end
        set_byte(1, 8'h21);
        serve(4);
        expect_launch(1, 8'h21, "lock2", w);
        req[1]      = 1'b0;
        req_lock[1] = 1'b0;
        serve(4);
        expect_launch(3, 8'h33, "lock_release", w);
        req[3] = 1'b0;
        serve(2);
        tick();
        check_idle("lock");
    endtask

    task automatic test_dead_serializer();
        int w;
        do_reset();
        set_byte(0, 8'h55);
        req = 4'b0001;
        expect_launch(0, 8'h55, "dead", w);
        req = '0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 15) begin
                n_tests++;
                if (err !== 1'b0 || fsm_state !== ST_WAIT_BUSY) begin
                    n_fail++;
                    $display("FAIL dead_early: err=%b state=%0d at 15 cycles, expected 0 and 2", err, fsm_state);
                end
            end
            if (c == 16) begin
                n_tests++;
                if (err !== 1'b1 || fsm_state !== ST_IDLE) begin
                    n_fail++;
                    $display("FAIL dead_timeout: err=%b state=%0d at 16 cycles, expected 1 and 0", err, fsm_state);
                end
            end
        end
        set_byte(2, 8'h77);
        req = 4'b0100;
        expect_launch(2, 8'h77, "dead_after", w);
        req = '0;
        serve(2);
        tick();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_sticky: err=%b expected 1", err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        // Continues from the dead-serializer test: rr_ptr=3, err=1.
        set_byte(1, 8'hA1);
        set_byte(2, 8'hA2);
        req = 4'b0110;
        expect_launch(1, 8'hA1, "midreset_pre", w);
        req[1] = 1'b0;
        tick();
        tx_busy = 1'b1;
        tick();
        n_tests++;
        if (fsm_state !== ST_WAIT_IDLE) begin
            n_fail++;
            $display("FAIL midreset_state: state=%0d expected 3", fsm_state);
        end
        req     = 4'b0110;
        reset   = 1'b1;
        tx_busy = 1'b0;
        tick();
        n_tests++;
        if (tx_start !== 1'b0 || ack !== 4'b0 || grant_id !== 2'd0 || tx_data !== 8'h00 ||
            active !== 1'b0 || err !== 1'b0 || fsm_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midreset_values: start=%b ack=%b gid=%0d data=%h active=%b err=%b state=%0d expected all 0",
                     tx_start, ack, grant_id, tx_data, active, err, fsm_state);
        end
        reset = 1'b0;
        expect_launch(1, 8'hA1, "midreset_first", w);
        req[1] = 1'b0;
        serve(2);
        expect_launch(2, 8'hA2, "midreset_second", w);
        req = '0;
        serve(2);
        tick();
    endtask

    task automatic test_busy_early();
        int w;
        int starts0;
        tick();
        starts0 = start_count;
        set_byte(3, 8'h5A);
        tx_busy = 1'b1;
        req     = 4'b1000;
        expect_launch(3, 8'h5A, "early", w);
        req = '0;
        tick();
        n_tests++;
        if (fsm_state !== ST_WAIT_BUSY) begin
            n_fail++;
            $display("FAIL early_wb0: state=%0d expected 2", fsm_state);
        end
        tx_busy = 1'b0;
        tick();
        n_tests++;
        if (fsm_state !== ST_WAIT_BUSY) begin
            n_fail++;
            $display("FAIL early_wb1: state=%0d expected 2", fsm_state);
        end
        tx_busy = 1'b1;
        tick();
        n_tests++;
        if (fsm_state !== ST_WAIT_IDLE) begin
            n_fail++;
            $display("FAIL early_wi: state=%0d expected 3", fsm_state);
        end
        repeat (3) tick();
        tx_busy = 1'b0;
        tick();
        check_idle("early");
        n_tests++;
        if (start_count - starts0 != 1) begin
            n_fail++;
            $display("FAIL early_starts: %0d launches, expected 1", start_count - starts0);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        start_count = 0;
        reset       = 1'b1;
        req         = '0;
        req_lock    = '0;
        req_data    = '0;
        tx_busy     = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_lock_burst();
        test_dead_serializer();
        test_reset_mid_frame();
        test_busy_early();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
